triloc_range_gen: RTL and testbench

Stimulus-side companion of the trilateration core. It takes the three anchor coordinate words and a ground-truth target position, and computes the floor Euclidean distance from the target to each anchor. The distances are packed into the radius word the trilateration core consumes as its Q input, so test and demo harnesses can generate consistent A/B/C/Q sets. The block is sequential: it uses one shared bit-serial integer square root that processes the anchors in turn.

---
 rtl/triloc_range_gen_pkg.sv | 38 +++
 rtl/triloc_range_gen_if.sv | 28 ++
 rtl/triloc_range_gen_isqrt.sv | 63 ++++++
 rtl/triloc_range_gen.sv | 163 ++++++++++++++++
 tb/tb_triloc_range_gen.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/triloc_range_gen_pkg.sv
// triloc_pkg: shared constants, FSM state type and squaring helpers for the
// trilateration range generator and the trilateration core.
//   N      coordinate width (signed two's complement)
//   CW     packed coordinate word width (x in upper half, y in lower half)
//   RW     radius width, DW squared-distance width, QW radius word width
//   Q*_LSB field offsets of rA/rB/rC inside the radius word
package triloc_pkg;
  localparam int N      = 8;
  localparam int CW     = 2 * N;
  localparam int RW     = N + 1;
  localparam int DW     = 2 * N + 2;
  localparam int QW     = 3 * N + 3;
  localparam int QA_LSB = 2 * N + 2;
  localparam int QB_LSB = N + 1;
  localparam int QC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    ROOT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Square of a signed RW-bit difference; the result is always non-negative
  // and below 2^(DW-1), so the DW-bit product never wraps.
  function automatic logic [DW-1:0] square_s(input logic signed [RW-1:0] v);
    logic signed [DW-1:0] e;
    e = {{(DW-RW){v[RW-1]}}, v};
    return e * e;
  endfunction

  // Square of an unsigned RW-bit root candidate.
  function automatic logic [DW-1:0] square_u(input logic [RW-1:0] v);
    logic [DW-1:0] e;
    e = {{(DW-RW){1'b0}}, v};
    return e * e;
  endfunction
endpackage

// File: rtl/triloc_range_gen_if.sv
// triloc_range_gen_if: request/response bundle of the range generator.
//   in_valid/in_ready    request handshake
//   p0/p1/p2/t_input     anchor A/B/C and target coordinate words
//   out_valid/out_ready  result handshake, q packed radius word
// master = stimulus side, slave = the range generator.
interface triloc_range_gen_if;
  import triloc_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] p0_input;
  logic [CW-1:0] p1_input;
  logic [CW-1:0] p2_input;
  logic [CW-1:0] t_input;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] q;

  modport master (
    output in_valid, p0_input, p1_input, p2_input, t_input, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, p0_input, p1_input, p2_input, t_input, out_ready,
    output in_ready, out_valid, q
  );
endinterface

// File: rtl/triloc_range_gen_isqrt.sv
// triloc_isqrt: bit-serial floor integer square root, one result bit per
// cycle, MSB first. load clears the root and arms bit N; the root is final
// in the cycle where done is high, exactly N+1 cycles after load.
//   clk, rst_n  clock and async active-low reset
//   load        start a new root (d must stay stable until done)
//   d           radicand
//   done        last-bit cycle; root is valid combinationally in this cycle
//   root        resolved root including the bit decided this cycle
module triloc_isqrt
  import triloc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic          done,
  output logic [RW-1:0] root
);
  logic [RW-1:0] root_q, root_d;
  logic [RW-1:0] bit_q, bit_d;
  logic [RW-1:0] trial_s;
  logic [RW-1:0] res_s;

  // Trial bit decision: keep the candidate bit if its square still fits in d.
  always_comb begin
    trial_s = root_q | bit_q;
    if (square_u(trial_s) <= d) begin
      res_s = trial_s;
    end else begin
      res_s = root_q;
    end
  end

  // Next-state for the partial root and the one-hot bit pointer.
  always_comb begin
    root_d = root_q;
    bit_d  = bit_q;
    if (load) begin
      root_d = {RW{1'b0}};
      bit_d  = {1'b1, {(RW-1){1'b0}}};
    end else if (bit_q != {RW{1'b0}}) begin
      root_d = res_s;
      bit_d  = bit_q >> 1;
    end else begin
      root_d = root_q;
      bit_d  = bit_q;
    end
  end

  // Root and bit-pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root_q <= {RW{1'b0}};
      bit_q  <= {RW{1'b0}};
    end else begin
      root_q <= root_d;
      bit_q  <= bit_d;
    end
  end

  assign done = bit_q[0];
  assign root = res_s;
endmodule

// File: rtl/triloc_range_gen.sv
// triloc_range_gen: computes floor Euclidean distance from a target to three
// anchors, one anchor at a time through a shared bit-serial square root, and
// presents the packed radius word {rA, rB, rC}.
//   clk, rst_n  clock and async active-low reset
//   bus         triloc_range_gen_if.slave (request in, radius word out)
module triloc_range_gen
  import triloc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  triloc_range_gen_if.slave  bus
);
  state_e        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [CW-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, t_q, t_d;
  logic [DW-1:0] d_q, d_d;
  logic [RW-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [QW-1:0] q_q, q_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic [CW-1:0]        anchor_s;
  logic signed [RW-1:0] dx_s, dy_s;
  logic [DW-1:0]        sq_s;
  logic                 load_s;
  logic                 done_s;
  logic [RW-1:0]        root_s;

  // Anchor mux for the anchor currently being ranged.
  always_comb begin
    case (k_q)
      2'd0:    anchor_s = p0_q;
      2'd1:    anchor_s = p1_q;
      default: anchor_s = p2_q;
    endcase
  end

  // Squarer: differences are sign-extended to N+1 bits so they never wrap.
  always_comb begin
    dx_s = {t_q[CW-1], t_q[CW-1:N]} - {anchor_s[CW-1], anchor_s[CW-1:N]};
    dy_s = {t_q[N-1], t_q[N-1:0]} - {anchor_s[N-1], anchor_s[N-1:0]};
    sq_s = square_s(dx_s) + square_s(dy_s);
  end

  triloc_isqrt u_isqrt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .d     (d_q),
    .done  (done_s),
    .root  (root_s)
  );

  // FSM and datapath next-state. rA/rB are staged internally so q only
  // changes when the complete word is published on entry to DONE.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    t_d         = t_q;
    d_d         = d_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    q_d         = q_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          p0_d       = bus.p0_input;
          p1_d       = bus.p1_input;
          p2_d       = bus.p2_input;
          t_d        = bus.t_input;
          k_d        = 2'd0;
          in_ready_d = 1'b0;
          state_d    = SQ;
        end else begin
          state_d = IDLE;
        end
      end
      SQ: begin
        d_d     = sq_s;
        load_s  = 1'b1;
        state_d = ROOT;
      end
      ROOT: begin
        if (done_s) begin
          case (k_q)
            2'd0: begin
              ra_d    = root_s;
              k_d     = 2'd1;
              state_d = SQ;
            end
            2'd1: begin
              rb_d    = root_s;
              k_d     = 2'd2;
              state_d = SQ;
            end
            default: begin
              q_d         = {ra_q, rb_q, root_s};
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
          endcase
        end else begin
          state_d = ROOT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      p0_q        <= {CW{1'b0}};
      p1_q        <= {CW{1'b0}};
      p2_q        <= {CW{1'b0}};
      t_q         <= {CW{1'b0}};
      d_q         <= {DW{1'b0}};
      ra_q        <= {RW{1'b0}};
      rb_q        <= {RW{1'b0}};
      q_q         <= {QW{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      t_q         <= t_d;
      d_q         <= d_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
endmodule

// File: tb/tb_triloc_range_gen.sv
module tb_triloc_range_gen;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  triloc_range_gen_if bus ();

  triloc_range_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor(sqrt) of the squared Euclidean distance, by plain search.
  function automatic int ref_radius(input logic [15:0] a, input logic [15:0] t);
    int xa, ya, xt, yt, dd, r;
    xa = $signed(a[15:8]);
    ya = $signed(a[7:0]);
    xt = $signed(t[15:8]);
    yt = $signed(t[7:0]);
    dd = (xt - xa) * (xt - xa) + (yt - ya) * (yt - ya);
    r = 0;
    while ((r + 1) * (r + 1) <= dd) r++;
    return r;
  endfunction

  function automatic logic [26:0] ref_q(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] t);
    logic [8:0] ra, rb, rc;
    ra = 9'(ref_radius(a, t));
    rb = 9'(ref_radius(b, t));
    rc = 9'(ref_radius(c, t));
    return {ra, rb, rc};
  endfunction

  function automatic logic [7:0] rnd_coord();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 8'h80;
    else if (s == 1) return 8'h7F;
    else return 8'($urandom);
  endfunction

  function automatic logic [15:0] rnd_point();
    logic [7:0] x, y;
    x = rnd_coord();
    y = rnd_coord();
    return {x, y};
  endfunction

  // Issue one request (caller ensures in_ready) and wait for out_valid.
  task automatic do_req(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] t, output int lat);
    bus.p0_input = a;
    bus.p1_input = b;
    bus.p2_input = c;
    bus.t_input  = t;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.p0_input = 16'($urandom);
    bus.p1_input = 16'($urandom);
    bus.p2_input = 16'($urandom);
    bus.t_input  = 16'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.p0_input = 16'h0;
    bus.p1_input = 16'h0;
    bus.p2_input = 16'h0;
    bus.t_input  = 16'h0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.q !== 27'd0) begin errors++; $display("FAIL reset_q: got %h expected 0", bus.q); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] t, input logic [26:0] want);
    int lat;
    logic [26:0] model;
    bus.out_ready = 1'b0;
    model = ref_q(a, b, c, t);
    do_req(a, b, c, t, lat);
    checks++;
    if (lat != 30) begin errors++; $display("FAIL %s_latency: got %0d expected 30", name, lat); end
    checks++;
    if (bus.q !== want) begin errors++; $display("FAIL %s_q: got %h expected %h", name, bus.q, want); end
    checks++;
    if (bus.q !== model) begin errors++; $display("FAIL %s_q_model: got %h expected %h", name, bus.q, model); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release: got out_valid=%b in_ready=%b expected 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] a, b, c, t;
    logic [26:0] model;
    bus.out_ready = 1'b0;
    a = 16'h0A14; b = 16'hF0E2; c = 16'h7F80; t = 16'h1E05;
    model = ref_q(a, b, c, t);
    bus.p0_input = a; bus.p1_input = b; bus.p2_input = c; bus.t_input = t;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_busy_in_ready: got %b expected 0", bus.in_ready); end
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.p0_input = 16'($urandom); bus.t_input = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 30) begin errors++; $display("FAIL bp_latency: got %0d expected 30", lat); end
    checks++;
    if (bus.q !== model) begin errors++; $display("FAIL bp_q: got %h expected %h", bus.q, model); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.q !== model || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: got out_valid=%b q=%h in_ready=%b expected 1/%h/0", bus.out_valid, bus.q, bus.in_ready, model);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.q !== model) begin errors++; $display("FAIL bp_q_hold: got %h expected %h", bus.q, model); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] a, b, c, t;
    bus.out_ready = 1'b0;
    a = 16'h3344; b = 16'hC0D0; c = 16'h0102; t = 16'hF8F9;
    bus.p0_input = a; bus.p1_input = b; bus.p2_input = c; bus.t_input = t;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== 27'd0) begin
      errors++; $display("FAIL mid_reset: got in_ready=%b out_valid=%b q=%h expected 1/0/0", bus.in_ready, bus.out_valid, bus.q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got out_valid=%b expected 0", bus.out_valid); end
    end
    do_req(a, b, c, t, lat);
    checks++;
    if (lat != 30) begin errors++; $display("FAIL mid_latency: got %0d expected 30", lat); end
    checks++;
    if (bus.q !== ref_q(a, b, c, t)) begin errors++; $display("FAIL mid_q: got %h expected %h", bus.q, ref_q(a, b, c, t)); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // out_ready held high throughout: one-cycle pulses, back-to-back requests.
  task automatic test_random(input int n, input logic fixed_anchors);
    int lat;
    logic [15:0] a, b, c, t;
    logic [26:0] model;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (fixed_anchors) begin
        a = {8'hF0, 8'h91}; b = {8'h6D, 8'h9D}; c = {8'hE0, 8'h6C};
      end else begin
        a = rnd_point(); b = rnd_point(); c = rnd_point();
      end
      t = rnd_point();
      model = ref_q(a, b, c, t);
      do_req(a, b, c, t, lat);
      checks++;
      if (lat != 30) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected 30", i, lat); end
      checks++;
      if (bus.q !== model) begin
        errors++; $display("FAIL rnd_q[%0d]: got %h expected %h (a=%h b=%h c=%h t=%h)", i, bus.q, model, a, b, c, t);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.q !== model) begin
        errors++; $display("FAIL rnd_pulse[%0d]: got out_valid=%b in_ready=%b q=%h expected 0/1/%h", i, bus.out_valid, bus.in_ready, bus.q, model);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vector("basic", 16'h0304, 16'hFA08, 16'h0081, 16'h0000, {9'd5, 9'd10, 9'd127});
    test_vector("extreme", 16'h8080, 16'h807F, 16'h7F80, 16'h7F7F, {9'd360, 9'd255, 9'd255});
    test_vector("floor", 16'h0101, 16'h0203, 16'h0000, 16'h0000, {9'd1, 9'd3, 9'd0});
    test_backpressure();
    test_reset_mid();
    test_random(1000, 1'b0);
    test_random(20, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
